// File: rtl/npu_bram_mem_if.sv
// Host-side burst port of npu_bram_mem: command, write-data and read-data streams.
interface npu_bram_mem_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rd;
    logic [DEPTH_LOG2-1:0] cmd_base;
    logic [DEPTH_LOG2:0]   cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [31:0]           wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [31:0]           rd_data;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_rd, cmd_base, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_base, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/npu_bram_mem.sv
// Dual-port word RAM: byte-enabled NPU port with 1-cycle read, plus a host
// burst port driven by a command FSM with valid/ready data streams.
module npu_bram_mem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] dwr,
    input  logic [3:0]  wren,
    output logic [31:0] drd,
    output logic        oor_err,
    npu_bram_mem_if.slave host
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    logic [31:0]           mem [DEPTH];
    state_t                state_q;
    logic [DEPTH_LOG2-1:0] base_q;
    logic [DEPTH_LOG2:0]   len_q, iss_q, dlv_q;
    logic                  cmd_ready_q, wr_ready_q, busy_q, oor_q;
    logic [31:0]           drd_q, pipe_q;
    logic [31:0]           fifo_q [2];
    logic                  wptr_q, rptr_q, infl_q;
    logic [1:0]            cnt_q;

    logic [DEPTH_LOG2-1:0] npu_idx, host_idx;
    logic                  npu_in_range, host_we, issue, pop;

    always_comb begin
        npu_idx      = addr[DEPTH_LOG2+1:2];
        npu_in_range = (addr[31:DEPTH_LOG2+2] == '0);
        host_idx     = base_q + iss_q[DEPTH_LOG2-1:0];
        host_we      = rst && (state_q == WRITE) && host.wr_valid && wr_ready_q;
        pop          = (cnt_q != 2'd0) && host.rd_ready;
        // A pop in the same cycle frees a slot, which keeps one word per cycle streaming.
        issue        = rst && (state_q == READ) && (iss_q != len_q) &&
                       (({1'b0, cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));
    end

    // NPU lane writes come after the host write so enabled NPU lanes win a collision.
    always_ff @(posedge clk) begin
        if (host_we) mem[host_idx] <= host.wr_data;
        if (rst && npu_in_range) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (wren[k]) mem[npu_idx][8*k +: 8] <= dwr[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            iss_q       <= '0;
            dlv_q       <= '0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            oor_q       <= 1'b0;
            drd_q       <= '0;
            pipe_q      <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            infl_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            drd_q <= npu_in_range ? mem[npu_idx] : '0;
            if (!npu_in_range) oor_q <= 1'b1;

            if (infl_q) begin
                fifo_q[wptr_q] <= pipe_q;
                wptr_q         <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
                dlv_q  <= dlv_q + 1'b1;
            end
            cnt_q  <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
            infl_q <= issue;
            if (issue) begin
                pipe_q <= mem[host_idx];
                iss_q  <= iss_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (host.cmd_valid && cmd_ready_q && (host.cmd_len != '0)) begin
                        base_q      <= host.cmd_base;
                        len_q       <= host.cmd_len;
                        iss_q       <= '0;
                        dlv_q       <= '0;
                        state_q     <= host.cmd_rd ? READ : WRITE;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        wr_ready_q  <= !host.cmd_rd;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (host_we) begin
                        iss_q <= iss_q + 1'b1;
                        if (iss_q == len_q - 1'b1) begin
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            wr_ready_q  <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (pop && (dlv_q == len_q - 1'b1)) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drd           = drd_q;
    assign oor_err       = oor_q;
    assign host.cmd_ready = cmd_ready_q;
    assign host.wr_ready  = wr_ready_q;
    assign host.busy      = busy_q;
    assign host.rd_valid  = (cnt_q != 2'd0);
    assign host.rd_data   = fifo_q[rptr_q];
endmodule

// File: tb/tb_npu_bram_mem.sv
// Directed self-checking bench for npu_bram_mem with DEPTH_LOG2 = 10.
module tb_npu_bram_mem;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] dwr = '0;
    logic [3:0]  wren = '0;
    logic [31:0] drd;
    logic        oor_err;
    int          checks = 0;
    int          errors = 0;

    npu_bram_mem_if #(.DEPTH_LOG2(DL)) host ();

    npu_bram_mem #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .addr(addr), .dwr(dwr), .wren(wren),
        .drd(drd), .oor_err(oor_err), .host(host)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic rd, input logic [DL-1:0] base, input logic [DL:0] len);
        host.cmd_valid = 1'b1;
        host.cmd_rd    = rd;
        host.cmd_base  = base;
        host.cmd_len   = len;
        tick();
        host.cmd_valid = 1'b0;
    endtask

    task automatic npu_read(input logic [31:0] a);
        addr = a;
        wren = 4'b0000;
        tick();
    endtask

    task automatic test_reset;
        host.cmd_valid = 1'b0; host.cmd_rd = 1'b0; host.cmd_base = '0; host.cmd_len = '0;
        host.wr_valid = 1'b0; host.wr_data = '0; host.rd_ready = 1'b0;
        rst = 1'b0;
        tick(); tick();
        checks++; if (drd !== 32'h0) begin errors++; $display("FAIL reset_drd got %h exp %h", drd, 32'h0); end
        checks++; if (host.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", host.cmd_ready); end
        checks++; if (host.busy !== 1'b0 || host.wr_ready !== 1'b0 || host.rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b wr_ready=%b rd_valid=%b exp 000", host.busy, host.wr_ready, host.rd_valid); end
        checks++; if (host.rd_data !== 32'h0 || oor_err !== 1'b0) begin
            errors++; $display("FAIL reset_rd_data_oor got %h/%b exp 0/0", host.rd_data, oor_err); end
        rst = 1'b1;
        tick();
        checks++; if (host.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready got %b exp 1", host.cmd_ready); end
    endtask

    task automatic test_npu_rw;
        addr = 32'h8; dwr = 32'hDEADBEEF; wren = 4'b1111;
        tick();
        wren = 4'b0010; dwr = 32'h0000_5500;
        tick();
        checks++; if (drd !== 32'hDEADBEEF) begin errors++; $display("FAIL npu_read_first got %h exp %h", drd, 32'hDEADBEEF); end
        npu_read(32'h8);
        checks++; if (drd !== 32'hDEAD55EF) begin errors++; $display("FAIL npu_byte_lane got %h exp %h", drd, 32'hDEAD55EF); end
    endtask

    task automatic test_host_write_wrap;
        send_cmd(1'b0, 10'd1020, 11'd8);
        checks++; if (host.busy !== 1'b1 || host.cmd_ready !== 1'b0 || host.wr_ready !== 1'b1) begin
            errors++; $display("FAIL wr_accept got busy=%b cmd_ready=%b wr_ready=%b exp 1 0 1", host.busy, host.cmd_ready, host.wr_ready); end
        host.wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host.wr_data = i;
            tick();
        end
        host.wr_valid = 1'b0;
        checks++; if (host.busy !== 1'b0 || host.cmd_ready !== 1'b1 || host.wr_ready !== 1'b0) begin
            errors++; $display("FAIL wr_done got busy=%b cmd_ready=%b wr_ready=%b exp 0 1 0", host.busy, host.cmd_ready, host.wr_ready); end
        npu_read(32'h0);
        checks++; if (drd !== 32'd4) begin errors++; $display("FAIL wr_wrap_word0 got %h exp %h", drd, 32'd4); end
        npu_read(32'hFFC);
        checks++; if (drd !== 32'd3) begin errors++; $display("FAIL wr_wrap_word1023 got %h exp %h", drd, 32'd3); end
    endtask

    task automatic test_host_read_backpressure;
        int          n = 0;
        logic        hold = 1'b0;
        logic [31:0] held = '0;
        send_cmd(1'b1, 10'd1020, 11'd8);
        checks++; if (host.busy !== 1'b1 || host.rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_accept got busy=%b rd_valid=%b exp 1 0", host.busy, host.rd_valid); end
        tick();
        checks++; if (host.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_latency_early got %b exp 0", host.rd_valid); end
        tick();
        checks++; if (host.rd_valid !== 1'b1 || host.rd_data !== 32'd0) begin
            errors++; $display("FAIL rd_latency_first got valid=%b data=%h exp 1 %h", host.rd_valid, host.rd_data, 32'd0); end
        for (int c = 0; c < 60 && n < 8; c++) begin
            host.rd_ready = ((c % 3) == 0);
            #1;
            if (hold) begin
                checks++; if (host.rd_data !== held) begin errors++; $display("FAIL rd_stable got %h exp %h", host.rd_data, held); end
            end
            if (host.rd_valid && host.rd_ready) begin
                checks++; if (host.rd_data !== n) begin errors++; $display("FAIL rd_data_seq got %h exp %h", host.rd_data, n); end
                n++;
            end
            hold = host.rd_valid && !host.rd_ready;
            held = host.rd_data;
            tick();
        end
        host.rd_ready = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL rd_count got %0d exp 8", n); end
        checks++; if (host.busy !== 1'b0 || host.rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_done got busy=%b rd_valid=%b exp 0 0", host.busy, host.rd_valid); end
    endtask

    task automatic test_out_of_range;
        addr = 32'h1000; dwr = 32'h1; wren = 4'b1111;
        tick();
        checks++; if (drd !== 32'h0 || oor_err !== 1'b1) begin
            errors++; $display("FAIL oor_access got drd=%h oor=%b exp 0 1", drd, oor_err); end
        npu_read(32'h0);
        checks++; if (drd !== 32'd4) begin errors++; $display("FAIL oor_no_write got %h exp %h", drd, 32'd4); end
        checks++; if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b exp 1", oor_err); end
    endtask

    task automatic test_collision;
        send_cmd(1'b0, 10'd5, 11'd1);
        host.wr_valid = 1'b1; host.wr_data = 32'h11223344;
        addr = 32'h14; dwr = 32'h0000_00AA; wren = 4'b0001;
        tick();
        host.wr_valid = 1'b0; wren = 4'b0000;
        npu_read(32'h14);
        checks++; if (drd !== 32'h112233AA) begin errors++; $display("FAIL collision_merge got %h exp %h", drd, 32'h112233AA); end
    endtask

    task automatic test_reset_midburst;
        for (int i = 0; i < 8; i++) begin
            addr = (100 + i) * 4; dwr = 32'h5000 + i; wren = 4'b1111;
            tick();
        end
        wren = 4'b0000;
        send_cmd(1'b0, 10'd100, 11'd8);
        host.wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host.wr_data = 32'hA0 + i;
            tick();
        end
        host.wr_data = 32'hA3;
        rst = 1'b0;
        tick();
        checks++; if (host.busy !== 1'b0 || host.wr_ready !== 1'b0 || host.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL abort_state got busy=%b wr_ready=%b cmd_ready=%b exp 0 0 0", host.busy, host.wr_ready, host.cmd_ready); end
        rst = 1'b1; host.wr_valid = 1'b0;
        tick();
        checks++; if (host.cmd_ready !== 1'b1 || host.busy !== 1'b0 || oor_err !== 1'b0) begin
            errors++; $display("FAIL abort_release got cmd_ready=%b busy=%b oor=%b exp 1 0 0", host.cmd_ready, host.busy, oor_err); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp_w;
            exp_w = (i < 3) ? 32'hA0 + i : 32'h5000 + i;
            npu_read((100 + i) * 4);
            checks++; if (drd !== exp_w) begin errors++; $display("FAIL abort_word%0d got %h exp %h", i, drd, exp_w); end
        end
        send_cmd(1'b0, 10'd7, 11'd0);
        checks++; if (host.busy !== 1'b0 || host.cmd_ready !== 1'b1 || host.wr_ready !== 1'b0) begin
            errors++; $display("FAIL zero_len got busy=%b cmd_ready=%b wr_ready=%b exp 0 1 0", host.busy, host.cmd_ready, host.wr_ready); end
    endtask

    task automatic test_back_to_back;
        send_cmd(1'b0, 10'd200, 11'd2);
        host.wr_valid = 1'b1;
        host.wr_data = 32'h77; tick();
        host.wr_data = 32'h88; tick();
        host.wr_valid = 1'b0;
        checks++; if (host.busy !== 1'b0 || host.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_wr_done got busy=%b cmd_ready=%b exp 0 1", host.busy, host.cmd_ready); end
        host.rd_ready = 1'b1;
        send_cmd(1'b1, 10'd200, 11'd2);
        checks++; if (host.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", host.busy); end
        tick(); tick();
        checks++; if (host.rd_valid !== 1'b1 || host.rd_data !== 32'h77) begin
            errors++; $display("FAIL b2b_rd0 got valid=%b data=%h exp 1 %h", host.rd_valid, host.rd_data, 32'h77); end
        tick();
        checks++; if (host.rd_valid !== 1'b1 || host.rd_data !== 32'h88) begin
            errors++; $display("FAIL b2b_rd1 got valid=%b data=%h exp 1 %h", host.rd_valid, host.rd_data, 32'h88); end
        tick();
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL b2b_rd_done got %b exp 0", host.busy); end
        host.rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_npu_rw();
        test_host_write_wrap();
        test_host_read_backpressure();
        test_out_of_range();
        test_collision();
        test_reset_midburst();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/npu_bram_mem.md
# npu_bram_mem

Dual-port 32-bit block-RAM responder that services the NPU-side BRAM controller: it accepts byte address, write data and 4-bit byte write enables, and returns read data one cycle later. A second, host-side burst port loads weights and inputs and drains results through a command FSM with valid/ready streams. The block sits between the NPU datapath's BRAM controller and the host/DMA fabric.

## Interface
- DEPTH_LOG2, 10, memory depth in 32-bit words (DEPTH = 2**DEPTH_LOG2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- addr  in  32  NPU byte address; word index = addr[DEPTH_LOG2+1:2]
- dwr  in  32  NPU write data
- wren  in  4  NPU byte-lane write enables; lane k = bits [8k+7:8k]
- drd  out  32  NPU read data, registered
- cmd_valid  in  1  host burst command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_rd  in  1  1 = read burst, 0 = write burst
- cmd_base  in  DEPTH_LOG2  first word index of burst
- cmd_len  in  DEPTH_LOG2+1  burst length in words (0..DEPTH)
- wr_valid / wr_ready  in / out  1  host write-data handshake
- wr_data  in  32  host write word
- rd_valid / rd_ready  out / in  1  host read-data handshake
- rd_data  out  32  host read word
- busy  out  1  burst in progress
- oor_err  out  1  sticky: NPU accessed address beyond DEPTH

## Operation
- NPU port, every cycle, no handshake: drd <= mem[word] (read-first: old data on same-cycle write); for each lane k with wren[k]=1, mem[word].lane k <= dwr.lane k.
- Out of range: addr[31:DEPTH_LOG2+2] != 0 -> write dropped, drd <= 0, oor_err <= 1 (stays 1 until reset).
- Host FSM states: IDLE, WRITE, READ.
  - IDLE: cmd_ready=1, busy=0. Handshake with cmd_len=0 -> stay IDLE, no effect. Otherwise latch base, len, clear counters; go WRITE (cmd_rd=0) or READ (cmd_rd=1).
  - WRITE: wr_ready=1, busy=1. Each wr_valid&wr_ready beat i writes all 4 lanes of mem[(base+i) mod DEPTH]. After beat len-1 -> IDLE.
  - READ: busy=1. Issue counter reads mem[(base+i) mod DEPTH] into 2-entry output FIFO; issue only when occupancy + in-flight < 2. Deliver counter counts rd_valid&rd_ready. After delivery len-1 -> IDLE.
- Host indices wrap modulo DEPTH; no error for wrap.
- Collision, both ports write same word same cycle: per lane, NPU-enabled lanes take dwr, others take host data. Host read of a word the NPU writes that cycle returns old data.
- wr_ready=0 and rd_valid=0 outside WRITE/READ; wr_valid in IDLE ignored.

## Timing
- Reset (rst=0 at edge): drd=0, cmd_ready=0 during reset cycle then 1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, oor_err=0, FIFO and counters cleared, state IDLE. Memory contents preserved.
- Reset mid-burst aborts it: untransferred words lost, words already written remain.
- NPU read latency 1: addr at edge T -> drd valid after T.
- Command accepted at T -> busy=1, cmd_ready=0 from T+1.
- Write burst: with wr_valid held 1, len words take len cycles from T+1; cmd_ready=1 the cycle after last beat.
- Read burst: first rd_valid earliest T+2; with rd_ready held 1, one word per cycle; rd_data stable while rd_valid & !rd_ready.
- Back-to-back: new command accepted the cycle after busy falls.

## Test plan
- Reset then NPU write addr=0x8, dwr=0xDEADBEEF, wren=4'b1111; next cycle read addr=0x8 -> drd=0xDEADBEEF one cycle later; wren=4'b0010, dwr=0x00005500 -> drd=0xDEAD55EF.
- Host write burst base=1020, len=8 (DEPTH_LOG2=10), words 0..7 -> words 1020..1023,0..3 hold 0..7 (wrap); NPU read addr=0x0 -> 4.
- Host read burst base=1020, len=8 with rd_ready toggling 1,0,0,1… -> rd_data sequence 0..7, no duplicates/drops, busy low after 8th handshake.
- NPU addr=0x1000 (DEPTH_LOG2=10) write 0x1 -> memory unchanged, drd=0, oor_err=1 until rst=0.
- Same-cycle collision on word 5: host writes 0x11223344, NPU wren=4'b0001 dwr=0xAA -> mem[5]=0x112233AA.
- rst=0 after 3 of 8 write beats -> busy=0, cmd_ready=1 next cycle, first 3 words written, rest unchanged; cmd_len=0 command -> busy stays 0.
